// File: rtl/sm_prod_accum.sv
// Streaming sign-magnitude product accumulator with a valid/ready frame-sum output.
// Optional build macro SM_ACCUM_SATURATE_EN: clamp the sum on overflow instead of wrapping.
module sm_prod_accum #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [8:0]       prod,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [7:0]       term_cnt,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [ACC_W-1:0] r_acc;
   logic [7:0]       r_cnt;
   logic             r_ovf;

   logic             w_in_xfer;
   logic             w_out_xfer;
   logic [ACC_W-1:0] w_mag;
   logic [ACC_W-1:0] w_term;
   logic [ACC_W:0]   w_sum;
   logic             w_sum_ovf;
   logic [ACC_W-1:0] w_acc_next;
   logic [7:0]       w_cnt_next;

   // Negating a zero magnitude gives zero, so -0 needs no special case.
   always_comb begin
      w_mag      = {{(ACC_W-8){1'b0}}, prod[7:0]};
      w_term     = prod[8] ? (~w_mag + 1'b1) : w_mag;
      w_sum      = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
      w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef SM_ACCUM_SATURATE_EN
      if (w_sum_ovf) begin
         w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         w_acc_next = w_sum[ACC_W-1:0];
      end
`else
      w_acc_next = w_sum[ACC_W-1:0];
`endif
      w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = ST_ACCUM;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
      w_in_xfer  = in_valid && in_ready;
      w_out_xfer = out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_in_xfer) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= r_ovf | w_sum_ovf;
         end else if (w_out_xfer) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
         end
      end
   end

   assign acc_out  = r_acc;
   assign term_cnt = r_cnt;
   assign ovf      = r_ovf;

endmodule
